// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: opcodes, FSM states and
// byte0 field positions.
package alu_pkg;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_AND     = 3'd2;
    localparam logic [2:0] OP_OR      = 3'd3;
    localparam logic [2:0] OP_XOR     = 3'd4;
    localparam logic [2:0] OP_SHADD   = 3'd5;
    localparam logic [2:0] OP_MUL6    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // byte0 = {sel, addr, rsvd}
    localparam int SEL_HI  = 7;
    localparam int SEL_LO  = 5;
    localparam int ADDR_HI = 4;
    localparam int ADDR_LO = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Byte-stream input and ALU issue bus of the command front end.
// master = the issue block, slave = byte source plus ALU.
interface alu_issue_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [2:0] alu_addr;
    logic       alu_en;
    logic       alu_out_en;

    modport master (
        input  in_data, in_valid, alu_out_en,
        output in_ready, alu_a, alu_b, alu_sel, alu_addr, alu_en
    );

    modport slave (
        output in_data, in_valid, alu_out_en,
        input  in_ready, alu_a, alu_b, alu_sel, alu_addr, alu_en
    );
endinterface

// File: rtl/alu_issue_timer.sv
// WAIT-state timeout counter; expire is asserted on the WAIT cycle whose
// edge brings the count to TIMEOUT_CYCLES without a completion.
module alu_issue_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic done,
    output logic expire
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run && !done)
            cnt <= cnt + 1'b1;
    end

    // completion in the limit cycle suppresses the expiry
    assign expire = run && !done && (cnt == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_issue.sv
// Byte-serial command assembler and issue sequencer in front of the ALU.
// Optional WAIT timeout is enabled with the ALU_ISSUE_TIMEOUT_EN macro.
module alu_issue
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.master bus,
    output logic        busy,
    output logic        err_sel,
    output logic        err_timeout,
    input  logic        err_clr,
    output logic [7:0]  issue_cnt
);

    if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    state_e     state, state_nxt;
    logic       acc;
    logic [2:0] hdr_sel;
    logic       hdr_ok;
    logic       hdr_bad;
    logic       to_expire;
    logic [7:0] a_q, b_q;
    logic [2:0] sel_q, addr_q;

    assign acc     = bus.in_valid && bus.in_ready;
    assign hdr_sel = bus.in_data[SEL_HI:SEL_LO];
    assign hdr_ok  = (state == S_IDLE) && acc && (hdr_sel != OP_ILLEGAL);
    assign hdr_bad = (state == S_IDLE) && acc && (hdr_sel == OP_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hdr_ok) state_nxt = S_GET_A;
            S_GET_A: if (acc)    state_nxt = S_GET_B;
            S_GET_B: if (acc)    state_nxt = S_ISSUE;
            S_ISSUE:             state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.alu_out_en || to_expire) state_nxt = S_IDLE;
            end
            default:             state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready = (state == S_IDLE) || (state == S_GET_A) || (state == S_GET_B);
    assign busy         = (state != S_IDLE);
    assign bus.alu_en   = (state == S_ISSUE);
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_sel  = sel_q;
    assign bus.alu_addr = addr_q;

    // operand fields hold until the next frame overwrites them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            issue_cnt <= '0;
            err_sel   <= 1'b0;
        end else begin
            if (hdr_ok) begin
                sel_q  <= hdr_sel;
                addr_q <= bus.in_data[ADDR_HI:ADDR_LO];
            end
            if ((state == S_GET_A) && acc) a_q <= bus.in_data;
            if ((state == S_GET_B) && acc) b_q <= bus.in_data;
            if (state == S_ISSUE) issue_cnt <= issue_cnt + 8'd1;
            if (hdr_bad)      err_sel <= 1'b1;
            else if (err_clr) err_sel <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    alu_issue_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == S_ISSUE),
        .run    (state == S_WAIT),
        .done   (bus.alu_out_en),
        .expire (to_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         err_timeout <= 1'b0;
        else if (to_expire) err_timeout <= 1'b1;
        else if (err_clr)   err_timeout <= 1'b0;
    end
`else
    assign to_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue against a frame-level model.
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy, err_sel, err_timeout;
    logic [7:0] issue_cnt;
    int         checks = 0;
    int         failures = 0;

    // frame-level model: last latched fields, issue count, sticky flags
    logic [7:0] m_a, m_b;
    logic [2:0] m_sel, m_addr;
    int         m_cnt;
    logic       m_err_sel, m_err_to;

    alu_issue_if bus();

    alu_issue #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .err_sel     (err_sel),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".a"},    bus.alu_a,    m_a);
        chk({tag, ".b"},    bus.alu_b,    m_b);
        chk({tag, ".sel"},  bus.alu_sel,  m_sel);
        chk({tag, ".addr"}, bus.alu_addr, m_addr);
        chk({tag, ".cnt"},  issue_cnt,    m_cnt % 256);
        chk({tag, ".esel"}, err_sel,      m_err_sel);
        chk({tag, ".eto"},  err_timeout,  m_err_to);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_sel = 0; m_addr = 0;
        m_cnt = 0; m_err_sel = 0; m_err_to = 0;
    endtask

    // random idle gap (with stray completions, which must be ignored), then one byte
    task automatic send_byte(input logic [7:0] d, input int max_gap);
        int gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
            bus.in_valid   = 1'b0;
            bus.alu_out_en = $urandom_range(1, 0);
            tick();
        end
        bus.alu_out_en = 1'b0;
        chk("in_ready_pre", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // sends a frame; for a legal one returns in the first WAIT cycle
    task automatic issue_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int max_gap);
        send_byte(b0, max_gap);
        if (b0[7:5] == 3'd7) begin
            m_err_sel = 1'b1;
            chk("ill.busy", busy, 1'b0);
            chk("ill.rdy",  bus.in_ready, 1'b1);
            chk("ill.en",   bus.alu_en, 1'b0);
            chk_regs("ill");
            return;
        end
        send_byte(b1, max_gap);
        chk("geta.busy", busy, 1'b1);
        send_byte(b2, max_gap);
        m_sel = b0[7:5]; m_addr = b0[4:2]; m_a = b1; m_b = b2;
        chk("iss.en",  bus.alu_en, 1'b1);
        chk("iss.rdy", bus.in_ready, 1'b0);
        chk_regs("iss");
        tick();
        m_cnt++;
        chk("wait.en",   bus.alu_en, 1'b0);
        chk("wait.busy", busy, 1'b1);
        chk_regs("wait");
    endtask

    task automatic complete(input int lat);
        repeat (lat - 1) begin
            chk("lat.rdy", bus.in_ready, 1'b0);
            tick();
        end
        bus.alu_out_en = 1'b1;
        tick();
        bus.alu_out_en = 1'b0;
        chk("done.rdy",  bus.in_ready, 1'b1);
        chk("done.busy", busy, 1'b0);
        chk("done.en",   bus.alu_en, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        model_reset();
        chk_regs(tag);
        chk({tag, ".en"},   bus.alu_en, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".rdy"},  bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] r0;
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.alu_out_en = 1'b0;
        model_reset();

        // reset state
        #12;
        chk_zero("rst");
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // basic ADD: sel=0 addr=1
        issue_frame(8'h04, 8'h12, 8'h34, 0);
        complete(3);
        chk("add.cnt", issue_cnt, 8'd1);

        // illegal opcode, then a normal AND frame, then clear
        issue_frame(8'hE0, 8'h00, 8'h00, 0);
        issue_frame(8'h40, 8'h05, 8'h03, 0);
        chk("and.sel", bus.alu_sel, 3'd2);
        complete(1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        m_err_sel = 1'b0;
        chk_regs("clr");

        // clear coinciding with a new illegal header: set wins
        err_clr = 1'b1;
        issue_frame(8'hFF, 8'h00, 8'h00, 0);
        err_clr = 1'b0;
        chk("setwins", err_sel, 1'b1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        m_err_sel = 1'b0;

        // stray completions in IDLE / GET_A
        bus.alu_out_en = 1'b1; tick(); bus.alu_out_en = 1'b0;
        chk("stray.idle", busy, 1'b0);
        send_byte(8'h0C, 0);
        bus.alu_out_en = 1'b1; tick(); bus.alu_out_en = 1'b0;
        chk("stray.geta", busy, 1'b1);
        chk("stray.rdy",  bus.in_ready, 1'b1);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        m_sel = 3'd0; m_addr = 3'd3; m_a = 8'hA5; m_b = 8'h5A;
        chk("stray.en", bus.alu_en, 1'b1);
        tick(); m_cnt++;
        chk_regs("stray");
        complete(2);

        // randomized frames, including illegal headers and gaps
        for (int i = 0; i < 40; i++) begin
            r0 = 8'($urandom);
            issue_frame(r0, 8'($urandom), 8'($urandom), 2);
            if (r0[7:5] != 3'd7) complete($urandom_range(10, 1));
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        m_err_sel = 1'b0;
        chk_regs("rnd");

`ifdef ALU_ISSUE_TIMEOUT_EN
        issue_frame(8'h24, 8'h11, 8'h22, 0);
        repeat (15) tick();
        chk("to.busy15", busy, 1'b1);
        chk("to.err15",  err_timeout, 1'b0);
        tick();
        m_err_to = 1'b1;
        chk("to.busy", busy, 1'b0);
        chk_regs("to");
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        m_err_to = 1'b0;
        issue_frame(8'h28, 8'h33, 8'h44, 0);
        complete(16);
        chk_regs("to.limit");
`else
        issue_frame(8'h24, 8'h11, 8'h22, 0);
        repeat (100) begin
            if (busy !== 1'b1) break;
            tick();
        end
        chk("hold.busy", busy, 1'b1);
        chk("hold.eto",  err_timeout, 1'b0);
        complete(1);
`endif

        // reset during GET_B
        send_byte(8'h14, 0);
        send_byte(8'h77, 0);
        rst_n = 1'b0; #2;
        chk_zero("rst.getb");
        @(posedge clk); #1 rst_n = 1'b1;
        bus.alu_out_en = 1'b1; tick(); bus.alu_out_en = 1'b0;
        chk("rst.getb.busy", busy, 1'b0);

        // reset during WAIT, late completion ignored
        issue_frame(8'h18, 8'h99, 8'h88, 0);
        tick();
        rst_n = 1'b0; #2;
        chk_zero("rst.wait");
        @(posedge clk); #1 rst_n = 1'b1;
        bus.alu_out_en = 1'b1; tick(); bus.alu_out_en = 1'b0;
        chk("late.busy", busy, 1'b0);
        chk_regs("late");

        // 256 issues wrap the counter
        for (int i = 0; i < 256; i++) begin
            r0 = {3'($urandom_range(6, 0)), 5'($urandom)};
            issue_frame(r0, 8'($urandom), 8'($urandom), 0);
            complete(1);
        end
        chk("wrap.cnt", issue_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
